// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared widths and sequencer state encoding for the neuron memory path
package snn_pkg;

  localparam int NEURONS_PER_GROUP = 16;
  localparam int POT_W             = 8;
  localparam int BETA_W            = 4;
  localparam int POT_WORD_W        = NEURONS_PER_GROUP * POT_W;
  localparam int BETA_WORD_W       = NEURONS_PER_GROUP * BETA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    OFFER   = 2'd2,
    WAIT_WB = 2'd3
  } seq_state_t;

endpackage

// File: rtl/potential_bank.sv
// rtl/potential_bank.sv - per-group potential/beta flop storage with one registered read port
module potential_bank
  import snn_pkg::*;
#(
  parameter int NUM_GROUPS = 8,
  parameter int GRP_W      = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_rd_en,
  input  logic [GRP_W-1:0]       i_rd_addr,
  output logic [POT_WORD_W-1:0]  o_rd_pot,
  output logic [BETA_WORD_W-1:0] o_rd_beta,
  input  logic                   i_seq_we,
  input  logic [GRP_W-1:0]       i_seq_addr,
  input  logic [POT_WORD_W-1:0]  i_seq_wdata,
  input  logic                   i_cfg_pot_we,
  input  logic                   i_cfg_beta_we,
  input  logic [GRP_W-1:0]       i_cfg_addr,
  input  logic [POT_WORD_W-1:0]  i_cfg_wdata
);

  localparam logic [GRP_W:0] LP_NG = (GRP_W+1)'(NUM_GROUPS);

  logic [POT_WORD_W-1:0]  r_pot  [NUM_GROUPS];
  logic [BETA_WORD_W-1:0] r_beta [NUM_GROUPS];
  logic [POT_WORD_W-1:0]  r_rd_pot;
  logic [BETA_WORD_W-1:0] r_rd_beta;

  logic                  w_pot_we;
  logic [GRP_W-1:0]      w_pot_addr;
  logic [POT_WORD_W-1:0] w_pot_wdata;
  logic                  w_pot_ok;
  logic                  w_beta_ok;

  // Sequencer writeback wins the shared potential write port.
  assign w_pot_we    = i_seq_we | i_cfg_pot_we;
  assign w_pot_addr  = i_seq_we ? i_seq_addr  : i_cfg_addr;
  assign w_pot_wdata = i_seq_we ? i_seq_wdata : i_cfg_wdata;
  assign w_pot_ok    = w_pot_we && ({1'b0, w_pot_addr} < LP_NG);
  assign w_beta_ok   = i_cfg_beta_we && ({1'b0, i_cfg_addr} < LP_NG);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_GROUPS; i++) begin
        r_pot[i]  <= '0;
        r_beta[i] <= '0;
      end
      r_rd_pot  <= '0;
      r_rd_beta <= '0;
    end else begin
      if (w_pot_ok) begin
        r_pot[w_pot_addr] <= w_pot_wdata;
      end
      if (w_beta_ok) begin
        r_beta[i_cfg_addr] <= i_cfg_wdata[BETA_WORD_W-1:0];
      end
      if (i_rd_en) begin
        r_rd_pot  <= r_pot[i_rd_addr];
        r_rd_beta <= r_beta[i_rd_addr];
      end
    end
  end

  assign o_rd_pot  = r_rd_pot;
  assign o_rd_beta = r_rd_beta;

endmodule

// File: rtl/potential_mem_sequencer.sv
// rtl/potential_mem_sequencer.sv - per-timestep sweep offering stored potentials/betas and writing back results
module potential_mem_sequencer
  import snn_pkg::*;
#(
  parameter int NUM_GROUPS = 8,
  parameter int GRP_W      = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [GRP_W-1:0]       grp_idx,
  output logic [POT_WORD_W-1:0]  ld_potential_out,
  output logic [BETA_WORD_W-1:0] ld_beta_out,
  output logic                   ld_valid,
  input  logic                   ld_ready,
  input  logic [POT_WORD_W-1:0]  wb_potential_in,
  input  logic                   wb_valid,
  input  logic                   cfg_we,
  input  logic                   cfg_sel,
  input  logic [GRP_W-1:0]       cfg_addr,
  input  logic [POT_WORD_W-1:0]  cfg_wdata
);

  localparam logic [GRP_W-1:0] LP_LAST = GRP_W'(NUM_GROUPS - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [GRP_W-1:0] r_grp_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_ld_valid;

  logic w_start_acc;
  logic w_fetch;
  logic w_handshake;
  logic w_wb_wr;
  logic w_last;
  logic w_cfg_ok;

  assign w_last = (r_grp_idx == LP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_fetch     = 1'b0;
    w_handshake = 1'b0;
    w_wb_wr     = 1'b0;
    case (r_state)
      IDLE: begin
        // The done cycle still sits in IDLE; a start there belongs to the old sweep.
        if (start && !r_done) begin
          w_start_acc = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = OFFER;
      end
      OFFER: begin
        if (r_ld_valid && ld_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = WAIT_WB;
        end
      end
      WAIT_WB: begin
        if (wb_valid) begin
          w_wb_wr     = 1'b1;
          w_state_nxt = w_last ? IDLE : FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grp_idx  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ld_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_acc) begin
        r_grp_idx <= '0;
        r_busy    <= 1'b1;
      end
      if (w_fetch) begin
        r_ld_valid <= 1'b1;
      end
      if (w_handshake) begin
        r_ld_valid <= 1'b0;
      end
      if (w_wb_wr) begin
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_grp_idx <= r_grp_idx + 1'b1;
        end
      end
    end
  end

  // Host writes land only between sweeps, so the bank is never changed under the processor.
  assign w_cfg_ok = cfg_we && (r_state == IDLE) && !r_busy;

  potential_bank #(
    .NUM_GROUPS (NUM_GROUPS),
    .GRP_W      (GRP_W)
  ) u_bank (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_rd_en       (w_fetch),
    .i_rd_addr     (r_grp_idx),
    .o_rd_pot      (ld_potential_out),
    .o_rd_beta     (ld_beta_out),
    .i_seq_we      (w_wb_wr),
    .i_seq_addr    (r_grp_idx),
    .i_seq_wdata   (wb_potential_in),
    .i_cfg_pot_we  (w_cfg_ok && !cfg_sel),
    .i_cfg_beta_we (w_cfg_ok && cfg_sel),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_wdata   (cfg_wdata)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign grp_idx  = r_grp_idx;
  assign ld_valid = r_ld_valid;

endmodule

// File: tb/tb_potential_mem_sequencer.sv
// tb/tb_potential_mem_sequencer.sv - directed/randomized sweeps against an array model of the stored groups
module tb_potential_mem_sequencer;

  localparam int NG = 8;
  localparam int GW = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic           busy;
  logic           done;
  logic [GW-1:0]  grp_idx;
  logic [127:0]   ld_potential_out;
  logic [63:0]    ld_beta_out;
  logic           ld_valid;
  logic           ld_ready;
  logic [127:0]   wb_potential_in;
  logic           wb_valid;
  logic           cfg_we;
  logic           cfg_sel;
  logic [GW-1:0]  cfg_addr;
  logic [127:0]   cfg_wdata;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int busy_cnt;

  logic [127:0] pot_mdl  [NG];
  logic [63:0]  beta_mdl [NG];
  int           rdy_dly  [NG];
  int           wb_dly   [NG];
  int           wb_mode  [NG];
  logic [127:0] wb_val   [NG];
  int           illegal_grp;
  int           abort_grp;
  bit           start_on_done;
  bit           cfg_with_start;

  always #5 clk = ~clk;

  potential_mem_sequencer #(
    .NUM_GROUPS (NG),
    .GRP_W      (GW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .grp_idx          (grp_idx),
    .ld_potential_out (ld_potential_out),
    .ld_beta_out      (ld_beta_out),
    .ld_valid         (ld_valid),
    .ld_ready         (ld_ready),
    .wb_potential_in  (wb_potential_in),
    .wb_valid         (wb_valid),
    .cfg_we           (cfg_we),
    .cfg_sel          (cfg_sel),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata)
  );

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < NG; i++) begin
      rdy_dly[i] = 0;
      wb_dly[i]  = 0;
      wb_mode[i] = 0;
      wb_val[i]  = '0;
    end
    illegal_grp    = -1;
    abort_grp      = -1;
    start_on_done  = 1'b0;
    cfg_with_start = 1'b0;
  endtask

  task automatic cfg_write(input logic sel, input int addr, input logic [127:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = GW'(addr);
    cfg_wdata = data;
    step();
    cfg_we = 1'b0;
    if (sel) beta_mdl[addr] = data[63:0];
    else     pot_mdl[addr]  = data;
  endtask

  task automatic sweep(input string name);
    int           exp_lat;
    int           k;
    logic [127:0] wv;
    exp_lat  = 3 * NG;
    cyc      = 0;
    busy_cnt = 0;
    start    = 1'b1;
    if (cfg_with_start) begin
      wv        = rnd128();
      cfg_we    = 1'b1;
      cfg_sel   = 1'b1;
      cfg_addr  = GW'(NG - 1);
      cfg_wdata = wv;
      beta_mdl[NG-1] = wv[63:0];
    end
    step();
    start  = 1'b0;
    cfg_we = 1'b0;
    chk({name, "_busy_start"}, 128'(busy), 128'(1));
    for (int g = 0; g < NG; g++) begin
      k = 0;
      while (ld_valid !== 1'b1 && k < 8) begin
        step();
        k++;
      end
      chk($sformatf("%s_ld_valid_g%0d", name, g), 128'(ld_valid), 128'(1));
      chk($sformatf("%s_grp_g%0d", name, g), 128'(grp_idx), 128'(g));
      chk($sformatf("%s_pot_g%0d", name, g), ld_potential_out, pot_mdl[g]);
      chk($sformatf("%s_beta_g%0d", name, g), 128'(ld_beta_out), 128'(beta_mdl[g]));
      if (g == illegal_grp) begin
        start           = 1'b1;
        cfg_we          = 1'b1;
        cfg_sel         = 1'b0;
        cfg_addr        = '0;
        cfg_wdata       = '1;
        wb_valid        = 1'b1;
        wb_potential_in = '1;
        step();
        start    = 1'b0;
        cfg_we   = 1'b0;
        wb_valid = 1'b0;
        exp_lat++;
        chk($sformatf("%s_illegal_valid_g%0d", name, g), 128'(ld_valid), 128'(1));
      end
      for (int d = 0; d < rdy_dly[g]; d++) begin
        step();
        exp_lat++;
      end
      if (rdy_dly[g] > 0) begin
        chk($sformatf("%s_bp_valid_g%0d", name, g), 128'(ld_valid), 128'(1));
        chk($sformatf("%s_bp_grp_g%0d", name, g), 128'(grp_idx), 128'(g));
        chk($sformatf("%s_bp_pot_g%0d", name, g), ld_potential_out, pot_mdl[g]);
      end
      ld_ready = 1'b1;
      step();
      ld_ready = 1'b0;
      chk($sformatf("%s_valid_drop_g%0d", name, g), 128'(ld_valid), 128'(0));
      if (g == abort_grp) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk({name, "_rst_busy"}, 128'(busy), 128'(0));
        chk({name, "_rst_valid"}, 128'(ld_valid), 128'(0));
        chk({name, "_rst_done"}, 128'(done), 128'(0));
        chk({name, "_rst_grp"}, 128'(grp_idx), 128'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < NG; i++) begin
          pot_mdl[i]  = '0;
          beta_mdl[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
          step();
          chk($sformatf("%s_no_done_%0d", name, i), 128'(done), 128'(0));
        end
        return;
      end
      for (int d = 0; d < wb_dly[g]; d++) begin
        step();
        exp_lat++;
      end
      case (wb_mode[g])
        0:       wv = pot_mdl[g];
        1:       wv = rnd128();
        default: wv = wb_val[g];
      endcase
      wb_valid        = 1'b1;
      wb_potential_in = wv;
      step();
      wb_valid  = 1'b0;
      pot_mdl[g] = wv;
    end
    chk({name, "_done"}, 128'(done), 128'(1));
    chk({name, "_busy_end"}, 128'(busy), 128'(0));
    chk({name, "_grp_end"}, 128'(grp_idx), 128'(NG - 1));
    chk({name, "_latency"}, 128'(cyc - 1), 128'(exp_lat));
    chk({name, "_busy_cycles"}, 128'(busy_cnt), 128'(exp_lat));
    if (start_on_done) start = 1'b1;
    step();
    start = 1'b0;
    chk({name, "_done_pulse"}, 128'(done), 128'(0));
    step();
    chk({name, "_idle_after"}, 128'(busy), 128'(0));
    chk({name, "_no_offer"}, 128'(ld_valid), 128'(0));
  endtask

  initial begin
    reset_n         = 1'b0;
    start           = 1'b0;
    ld_ready        = 1'b0;
    wb_valid        = 1'b0;
    wb_potential_in = '0;
    cfg_we          = 1'b0;
    cfg_sel         = 1'b0;
    cfg_addr        = '0;
    cfg_wdata       = '0;
    for (int i = 0; i < NG; i++) begin
      pot_mdl[i]  = '0;
      beta_mdl[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_valid", 128'(ld_valid), 128'(0));
    chk("rst_grp", 128'(grp_idx), 128'(0));
    chk("rst_pot", ld_potential_out, 128'(0));
    chk("rst_beta", 128'(ld_beta_out), 128'(0));
    reset_n = 1'b1;
    step();

    clear_plan();
    sweep("zero");

    for (int i = 0; i < NG; i++) begin
      cfg_write(1'b0, i, rnd128());
      cfg_write(1'b1, i, rnd128());
    end
    cfg_write(1'b0, 3, 128'h0102030405060708090a0b0c0d0e0f10);
    cfg_write(1'b1, 3, 128'h1111111111111111);

    clear_plan();
    rdy_dly[2]     = 4;
    wb_mode[5]     = 2;
    wb_val[5]      = {16{8'hA5}};
    wb_dly[6]      = int'($urandom_range(0, 3));
    cfg_with_start = 1'b1;
    sweep("cfg");

    clear_plan();
    for (int i = 0; i < NG; i++) begin
      rdy_dly[i] = int'($urandom_range(0, 2));
      wb_dly[i]  = int'($urandom_range(0, 2));
      wb_mode[i] = (i == 5) ? 0 : 1;
    end
    illegal_grp   = 1;
    start_on_done = 1'b1;
    sweep("rand");

    clear_plan();
    abort_grp = 4;
    sweep("abort");

    clear_plan();
    sweep("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
